bank_scan_reader: RTL and testbench



---
 rtl/bank_scan_reader_pkg.sv | 23 ++
 rtl/bank_scan_reader_if.sv | 28 ++
 rtl/bank_scan_reader_edge_sync.sv | 26 ++
 rtl/bank_scan_reader.sv | 86 ++++++++
 tb/tb_bank_scan_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_scan_reader_pkg.sv
// Shared constants and types for the bank scan reader: mode encodings,
// reader state enum and the one-hot bank decode.
package bank_scan_reader_pkg;

    localparam int NUM_BANKS = 4;
    localparam int ADDR_W    = 2;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [ADDR_W-1:0] idx);
        bank_onehot      = '0;
        bank_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/bank_scan_reader_if.sv
// Control and display bundle between the bank storage/switch side and the
// reader: master drives bank contents and controls, slave returns the view.
interface bank_scan_reader_if
    import bank_scan_reader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NBANK  = 4
);
    logic [NBANK*DATA_W-1:0] bank_data;
    logic [1:0]              mode;
    logic [ADDR_W-1:0]       man_sel;
    logic                    step_btn;
    logic                    hold;
    logic [ADDR_W-1:0]       cur_sel;
    logic [NBANK-1:0]        cur_onehot;
    logic [DATA_W-1:0]       cur_data;
    logic                    frame_done;

    modport master (
        output bank_data, mode, man_sel, step_btn, hold,
        input  cur_sel, cur_onehot, cur_data, frame_done
    );

    modport slave (
        input  bank_data, mode, man_sel, step_btn, hold,
        output cur_sel, cur_onehot, cur_data, frame_done
    );
endinterface

// File: rtl/bank_scan_reader_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; emits one clk-wide pulse per low-to-high transition.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic meta, sync, prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse = sync & ~prev;
endmodule

// File: rtl/bank_scan_reader.sv
// Sequential reader for four storage banks: manual select, timed auto-scan or
// button single-step, presenting a registered byte, index and one-hot view.
module bank_scan_reader #(
    parameter int DATA_W = 8,
    parameter int NBANK  = 4,
    parameter int DWELL  = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    bank_scan_reader_if.slave bus
);
    import bank_scan_reader_pkg::*;

    localparam int             CNT_W    = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t             state, next_state;
    logic [ADDR_W-1:0]  ptr, ptr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               step_pulse;
    logic               advance;
    logic               wrap;

    edge_sync u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.step_btn),
        .pulse (step_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_MANUAL;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        next_state = ST_MANUAL;
        ptr_next   = ptr;
        cnt_next   = '0;
        advance    = 1'b0;

        case (bus.mode)
            MODE_SCAN: next_state = ST_SCAN;
            MODE_STEP: next_state = ST_STEP;
            default:   next_state = ST_MANUAL;
        endcase

        case (state)
            ST_MANUAL: ptr_next = bus.man_sel;
            ST_SCAN: begin
                if (bus.hold)             cnt_next = cnt;
                else if (cnt == CNT_LAST) advance  = 1'b1;
                else                      cnt_next = cnt + 1'b1;
            end
            ST_STEP:   advance = step_pulse & ~bus.hold;
            default:   ptr_next = bus.man_sel;
        endcase

        if (advance) ptr_next = ptr + 1'b1;

        // Leaving SCAN: the dwell count starts fresh when SCAN is next entered.
        if (next_state != ST_SCAN) cnt_next = '0;
    end

    assign wrap = advance && (ptr == ADDR_W'(NUM_BANKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            cnt            <= '0;
            bus.cur_sel    <= '0;
            bus.cur_onehot <= bank_onehot('0);
            bus.cur_data   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            ptr            <= ptr_next;
            cnt            <= cnt_next;
            bus.cur_sel    <= ptr;
            bus.cur_onehot <= bank_onehot(ptr);
            bus.cur_data   <= bus.bank_data[int'(ptr)*DATA_W +: DATA_W];
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_bank_scan_reader.sv
// Directed bench for bank_scan_reader with DWELL=4: reset, manual select,
// live update, scan with hold, single-step and reset during a scan.
module tb_bank_scan_reader;
    import bank_scan_reader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bank_scan_reader_if #(.DATA_W(8), .NBANK(4)) bus ();

    bank_scan_reader #(.DATA_W(8), .NBANK(4), .DWELL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.bank_data = 32'hDDCC_BBAA;
        bus.mode      = MODE_MANUAL;
        bus.man_sel   = 2'd3;
        bus.hold      = 1'b0;
        bus.step_btn  = 1'b0;
        rst           = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (bus.cur_sel !== 2'd3) begin
            miscompares++; $display("FAIL pre_reset_sel got %0d want 3", bus.cur_sel);
        end
        vectors++;
        if (bus.cur_data !== 8'hDD) begin
            miscompares++; $display("FAIL pre_reset_data got %h want dd", bus.cur_data);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.cur_sel !== 2'd0) begin
            miscompares++; $display("FAIL async_reset_sel got %0d want 0", bus.cur_sel);
        end
        vectors++;
        if (bus.cur_onehot !== 4'b0001) begin
            miscompares++; $display("FAIL async_reset_onehot got %b want 0001", bus.cur_onehot);
        end
        vectors++;
        if (bus.cur_data !== 8'h00) begin
            miscompares++; $display("FAIL async_reset_data got %h want 00", bus.cur_data);
        end
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_frame got %b want 0", bus.frame_done);
        end
        bus.man_sel = 2'd0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        vectors++;
        if (bus.cur_sel !== 2'd0 || bus.cur_onehot !== 4'b0001) begin
            miscompares++;
            $display("FAIL post_reset_sel got %0d/%b want 0/0001", bus.cur_sel, bus.cur_onehot);
        end
        vectors++;
        if (bus.cur_data !== 8'hAA) begin
            miscompares++; $display("FAIL post_reset_data got %h want aa", bus.cur_data);
        end
    endtask

    task automatic test_manual();
        bus.man_sel = 2'd2;
        tick();
        vectors++;
        if (bus.cur_sel !== 2'd0) begin
            miscompares++; $display("FAIL manual_latency1 got %0d want 0", bus.cur_sel);
        end
        tick();
        vectors++;
        if (bus.cur_sel !== 2'd2) begin
            miscompares++; $display("FAIL manual_sel got %0d want 2", bus.cur_sel);
        end
        vectors++;
        if (bus.cur_onehot !== 4'b0100) begin
            miscompares++; $display("FAIL manual_onehot got %b want 0100", bus.cur_onehot);
        end
        vectors++;
        if (bus.cur_data !== 8'hCC) begin
            miscompares++; $display("FAIL manual_data got %h want cc", bus.cur_data);
        end
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++; $display("FAIL manual_frame got %b want 0", bus.frame_done);
        end
    endtask

    task automatic test_live_update();
        bus.man_sel = 2'd1;
        repeat (2) tick();
        vectors++;
        if (bus.cur_data !== 8'hBB) begin
            miscompares++; $display("FAIL live_before got %h want bb", bus.cur_data);
        end
        bus.bank_data[15:8] = 8'h5A;
        tick();
        vectors++;
        if (bus.cur_data !== 8'h5A) begin
            miscompares++; $display("FAIL live_after got %h want 5a", bus.cur_data);
        end
    endtask

    // Entering SCAN with ptr=0: cur_sel is 0 up to cycle 5, then each bank for 4
    // cycles; the 3->0 wrap lands on cycle 17, cur_sel returns to 0 on cycle 18.
    task automatic test_scan();
        bus.man_sel = 2'd0;
        repeat (2) tick();
        bus.mode = MODE_SCAN;
        for (int k = 1; k <= 18; k++) begin
            logic [1:0] exp_sel;
            tick();
            exp_sel = (k < 2) ? 2'd0 : 2'((k - 2) / 4);
            vectors++;
            if (bus.cur_sel !== exp_sel) begin
                miscompares++; $display("FAIL scan_sel[%0d] got %0d want %0d", k, bus.cur_sel, exp_sel);
            end
            vectors++;
            if (bus.frame_done !== (k == 17)) begin
                miscompares++; $display("FAIL scan_frame[%0d] got %b want %b", k, bus.frame_done, k == 17);
            end
        end
    endtask

    // Continues the scan timeline; hold is raised with bank 2 one cycle into its dwell.
    task automatic test_scan_hold();
        for (int k = 19; k <= 26; k++) begin
            logic [1:0] exp_sel;
            tick();
            exp_sel = 2'((k - 2) / 4);
            vectors++;
            if (bus.cur_sel !== exp_sel) begin
                miscompares++; $display("FAIL scan2_sel[%0d] got %0d want %0d", k, bus.cur_sel, exp_sel);
            end
        end
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (bus.cur_sel !== 2'd2 || bus.cur_data !== 8'hCC) begin
                miscompares++;
                $display("FAIL hold_frozen[%0d] got %0d/%h want 2/cc", i, bus.cur_sel, bus.cur_data);
            end
        end
        bus.hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.cur_sel !== 2'd2) begin
                miscompares++; $display("FAIL hold_remaining[%0d] got %0d want 2", i, bus.cur_sel);
            end
        end
        tick();
        vectors++;
        if (bus.cur_sel !== 2'd3) begin
            miscompares++; $display("FAIL hold_advance got %0d want 3", bus.cur_sel);
        end
    endtask

    task automatic do_press(input logic [1:0] old_sel, input logic [1:0] new_sel,
                            input logic exp_wrap);
        bus.step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) bus.step_btn = 1'b0;
            if (i == 3) begin
                vectors++;
                if (bus.cur_sel !== old_sel || bus.frame_done !== exp_wrap) begin
                    miscompares++;
                    $display("FAIL step_edge3 got %0d/%b want %0d/%b",
                             bus.cur_sel, bus.frame_done, old_sel, exp_wrap);
                end
            end
            if (i == 4) begin
                vectors++;
                if (bus.cur_sel !== new_sel || bus.frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL step_edge4 got %0d/%b want %0d/0",
                             bus.cur_sel, bus.frame_done, new_sel);
                end
            end
            if (i == 10) begin
                vectors++;
                if (bus.cur_sel !== new_sel) begin
                    miscompares++; $display("FAIL step_settled got %0d want %0d", bus.cur_sel, new_sel);
                end
            end
        end
    endtask

    task automatic test_step();
        bus.mode    = MODE_MANUAL;
        bus.man_sel = 2'd0;
        repeat (3) tick();
        bus.mode = MODE_STEP;
        repeat (2) tick();
        vectors++;
        if (bus.cur_sel !== 2'd0) begin
            miscompares++; $display("FAIL step_start got %0d want 0", bus.cur_sel);
        end
        do_press(2'd0, 2'd1, 1'b0);
        do_press(2'd1, 2'd2, 1'b0);
        do_press(2'd2, 2'd3, 1'b0);
        do_press(2'd3, 2'd0, 1'b1);
        bus.hold = 1'b1;
        do_press(2'd0, 2'd0, 1'b0);
        bus.hold = 1'b0;
        repeat (5) tick();
        vectors++;
        if (bus.cur_sel !== 2'd0) begin
            miscompares++; $display("FAIL step_not_queued got %0d want 0", bus.cur_sel);
        end
    endtask

    task automatic test_reset_mid_scan();
        bus.mode = MODE_SCAN;
        repeat (6) tick();
        vectors++;
        if (bus.cur_sel !== 2'd1) begin
            miscompares++; $display("FAIL midscan_pre got %0d want 1", bus.cur_sel);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.cur_sel !== 2'd0 || bus.cur_onehot !== 4'b0001 || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midscan_reset got %0d/%b/%b want 0/0001/0",
                     bus.cur_sel, bus.cur_onehot, bus.frame_done);
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic [1:0] exp_sel;
            tick();
            exp_sel = (k == 6) ? 2'd1 : 2'd0;
            vectors++;
            if (bus.cur_sel !== exp_sel) begin
                miscompares++; $display("FAIL midscan_restart[%0d] got %0d want %0d", k, bus.cur_sel, exp_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_live_update();
        test_scan();
        test_scan_hold();
        test_step();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
